ctrl_sequencer: RTL and testbench

//  Multi-cycle CPU control unit. Owns the instruction register and the cycle/wait state

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/ctrl_decode.sv | 70 +++++++
 rtl/ctrl_sequencer.sv | 170 +++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle control sequencer.
//   state_t   - sequencer states (IDLE, C0, C1)
//   strobes_t - single-bit datapath strobes produced by ctrl_decode
//   CLS_*     - opcode-class patterns on the upper instruction bits
//   is_two_cycle / is_mem - instruction class helpers
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_C0   = 2'd1,
    ST_C1   = 2'd2
  } state_t;

  // Opcode classes, matched against ir[7:6] or ir[7:5]
  localparam logic [1:0] CLS_MEM    = 2'b10;   // ir[7:6]: load/store
  localparam logic [1:0] CLS_ALU    = 2'b01;   // ir[7:6]: single-cycle ALU
  localparam logic [2:0] CLS_JUMP   = 3'b111;  // ir[7:5]
  localparam logic [2:0] CLS_SIMPLE = 3'b000;  // ir[7:5]
  localparam logic [2:0] CLS_SP     = 3'b001;  // ir[7:5]

  typedef struct packed {
    logic m;
    logic s;
    logic j;
    logic lj;
    logic cli;
    logic ljr;
    logic mw;
    logic mc;
    logic rd;
    logic wr;
    logic y;
    logic wa;
    logic isp;
    logic wc;
  } strobes_t;

  function automatic logic is_two_cycle(input logic [7:0] ir);
    return ir[7];
  endfunction

  function automatic logic is_mem(input logic [7:0] ir);
    return ir[7:6] == CLS_MEM;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: pure combinational instruction decoder.
// Ports:
//   i_ir    [7:0]        instruction register
//   i_cycle              0 = C0, 1 = C1
//   i_carry              carry flag for conditional jump
//   o_strb  strobes_t    raw single-bit strobes (ungated)
//   o_rs    [RS_W-1:0]   register select
//   o_alu   [3:0]        ALU op
//   o_sig   [2**SEL_W-1:0] one-hot signal strobe
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned RS_W  = 2
) (
  input  logic [7:0]            i_ir,
  input  logic                  i_cycle,
  input  logic                  i_carry,
  output strobes_t              o_strb,
  output logic [RS_W-1:0]       o_rs,
  output logic [3:0]            o_alu,
  output logic [2**SEL_W-1:0]   o_sig
);

  logic w_c0;
  logic w_c1;
  logic w_m;
  logic w_jtype;
  logic w_simple;
  logic w_lj;
  logic w_isalu;
  logic w_isp;
  logic w_issig;

  assign w_c0     = ~i_cycle;
  assign w_c1     = i_cycle;
  assign w_m      = (i_ir[7:6] == CLS_MEM) & w_c1;
  assign w_jtype  = (i_ir[7:5] == CLS_JUMP);
  assign w_simple = (i_ir[7:5] == CLS_SIMPLE);
  assign w_isp    = (i_ir[7:5] == CLS_SP);
  assign w_lj     = w_simple & i_ir[4] & ~i_ir[3];
  // Register-form ALU ops in C0, or immediate-form ALU result in C1
  assign w_isalu  = (i_ir[7:6] == CLS_ALU) | (w_c1 & i_ir[6] & ~i_ir[5]);
  assign w_issig  = w_simple & i_ir[4] & i_ir[3] & w_c0;

  assign o_strb.m   = w_m;
  assign o_strb.s   = i_ir[4];
  assign o_strb.j   = w_jtype & w_c1 & ~(i_ir[4] & i_carry);
  assign o_strb.lj  = w_lj;
  assign o_strb.cli = w_lj & i_ir[1];
  assign o_strb.ljr = w_lj & i_ir[2];
  assign o_strb.mw  = w_m & i_ir[5];
  assign o_strb.mc  = i_ir[7] & w_c0;
  assign o_strb.rd  = w_simple & ~i_ir[4] & i_ir[2];
  assign o_strb.wr  = w_simple & ~i_ir[4] & i_ir[3];
  assign o_strb.y   = i_ir[5];
  assign o_strb.wa  = (w_m & ~i_ir[5]) | (w_isalu & ~(i_ir[4] & ~i_ir[3]));
  assign o_strb.isp = w_isp;
  assign o_strb.wc  = i_ir[4] & (w_isalu | w_isp);

  assign o_rs     = i_ir[RS_W-1:0];
  assign o_alu[3] = i_ir[6] ? i_ir[3] : ~i_ir[7];
  assign o_alu[2:0] = i_ir[2:0] & {3{i_ir[6]}};

  always_comb begin
    o_sig = '0;
    if (w_issig) o_sig[i_ir[SEL_W-1:0]] = 1'b1;
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle CPU control unit. Holds the instruction register,
// the IDLE/C0/C1 state and the memory wait counter; accepts instructions over a
// valid/ready handshake and drives the datapath strobes.
// Ports:
//   clk, rst_n (async, active low)
//   inst[7:0], inst_valid, inst_ready   fetch handshake
//   carry, mem_ready                    condition / memory completion
//   cycle, busy, timeout                sequencer status
//   M,S,J,LJ,CLI,LJR,MW,MC,RD,WR,Y,WA,ISP,WC, RS, ALU, SIG   datapath strobes
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned WAIT_W = 4,
  parameter int unsigned RS_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          inst,
  input  logic                inst_valid,
  output logic                inst_ready,
  input  logic                carry,
  input  logic                mem_ready,
  output logic                cycle,
  output logic                busy,
  output logic                timeout,
  output logic                M,
  output logic                S,
  output logic                J,
  output logic                LJ,
  output logic                CLI,
  output logic                LJR,
  output logic                MW,
  output logic                MC,
  output logic                RD,
  output logic                WR,
  output logic                Y,
  output logic                WA,
  output logic                ISP,
  output logic                WC,
  output logic [RS_W-1:0]     RS,
  output logic [3:0]          ALU,
  output logic [2**SEL_W-1:0] SIG
);

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_ir;
  logic [WAIT_W-1:0]   r_wait;

  logic                w_ready;
  logic                w_accept;
  logic                w_active;
  logic                w_cycle;
  logic                w_commit;
  logic                w_timeout;
  logic                w_complete;

  strobes_t            w_raw;
  strobes_t            w_strb;
  logic [RS_W-1:0]     w_rs;
  logic [3:0]          w_alu;
  logic [2**SEL_W-1:0] w_sig;

  ctrl_decode #(
    .SEL_W (SEL_W),
    .RS_W  (RS_W)
  ) u_decode (
    .i_ir    (r_ir),
    .i_cycle (w_cycle),
    .i_carry (carry),
    .o_strb  (w_raw),
    .o_rs    (w_rs),
    .o_alu   (w_alu),
    .o_sig   (w_sig)
  );

  assign w_complete = ~is_mem(r_ir) | mem_ready;
  assign w_accept   = inst_valid & w_ready;

  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    w_active  = 1'b0;
    w_cycle   = 1'b0;
    w_commit  = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (inst_valid) w_next = ST_C0;
      end
      ST_C0: begin
        w_active = 1'b1;
        if (is_two_cycle(r_ir)) begin
          w_next = ST_C1;
        end else begin
          w_ready  = 1'b1;
          w_commit = 1'b1;
          w_next   = inst_valid ? ST_C0 : ST_IDLE;
        end
      end
      ST_C1: begin
        w_active = 1'b1;
        w_cycle  = 1'b1;
        if (w_complete) begin
          w_ready  = 1'b1;
          w_commit = 1'b1;
          w_next   = inst_valid ? ST_C0 : ST_IDLE;
        end else if (r_wait == '1) begin
          // Wait budget exhausted: abandon the access without committing
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_ir <= inst;
      if (r_state == ST_C1 && !w_complete && !w_timeout)
        r_wait <= r_wait + WAIT_W'(1);
      else
        r_wait <= '0;
    end
  end

  // Level strobes follow the state; register/memory writes only fire in the
  // cycle the instruction retires so a stall or timeout never writes twice.
  always_comb begin
    w_strb = w_active ? w_raw : '0;
    if (!w_commit) begin
      w_strb.mw = 1'b0;
      w_strb.wa = 1'b0;
      w_strb.wc = 1'b0;
    end
  end

  assign inst_ready = w_ready;
  assign cycle      = w_cycle;
  assign busy       = w_active;
  assign timeout    = w_timeout;

  assign M   = w_strb.m;
  assign S   = w_strb.s;
  assign J   = w_strb.j;
  assign LJ  = w_strb.lj;
  assign CLI = w_strb.cli;
  assign LJR = w_strb.ljr;
  assign MW  = w_strb.mw;
  assign MC  = w_strb.mc;
  assign RD  = w_strb.rd;
  assign WR  = w_strb.wr;
  assign Y   = w_strb.y;
  assign WA  = w_strb.wa;
  assign ISP = w_strb.isp;
  assign WC  = w_strb.wc;

  assign RS  = w_active ? w_rs  : '0;
  assign ALU = w_active ? w_alu : '0;
  assign SIG = w_active ? w_sig : '0;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Testbench for ctrl_sequencer: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_ctrl_sequencer;

  localparam int SEL_W    = 3;
  localparam int WAIT_W   = 4;
  localparam int RS_W     = 2;
  localparam int MAX_WAIT = 2**WAIT_W - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] inst;
  logic inst_valid, carry, mem_ready;
  logic inst_ready, cycle, busy, timeout;
  logic M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, WA, ISP, WC;
  logic [RS_W-1:0] RS;
  logic [3:0] ALU;
  logic [2**SEL_W-1:0] SIG;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  ctrl_sequencer #(
    .SEL_W  (SEL_W),
    .WAIT_W (WAIT_W),
    .RS_W   (RS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .carry(carry), .mem_ready(mem_ready),
    .cycle(cycle), .busy(busy), .timeout(timeout),
    .M(M), .S(S), .J(J), .LJ(LJ), .CLI(CLI), .LJR(LJR), .MW(MW), .MC(MC),
    .RD(RD), .WR(WR), .Y(Y), .WA(WA), .ISP(ISP), .WC(WC),
    .RS(RS), .ALU(ALU), .SIG(SIG)
  );

  typedef struct packed {
    logic        ready, cyc, bsy, to;
    logic [13:0] strb;   // M,S,J,LJ,CLI,LJR,MW,MC,RD,WR,Y,WA,ISP,WC
    logic [1:0]  rs;
    logic [3:0]  alu;
    logic [7:0]  sig;
  } exp_t;

  // Model: an instruction in flight, which of its two phases it is in, and
  // how many memory stalls it has suffered so far.
  bit         m_busy   = 1'b0;
  bit         m_in_c1  = 1'b0;
  logic [7:0] m_ir     = '0;
  int         m_stalls = 0;

  function automatic exp_t model_out(input bit bz, input bit in_c1,
                                     input logic [7:0] ir, input int stalls,
                                     input logic cy, input logic mr);
    exp_t e;
    bit two, mem, done, c0, c1, m, lj, simple, isalu, isp, issig;
    e = '0;
    if (!bz) begin
      e.ready = 1'b1;
      return e;
    end
    two  = ir[7];
    mem  = (ir[7:6] == 2'b10);
    done = in_c1 ? (!mem || mr) : !two;
    c0 = !in_c1;
    c1 = in_c1;
    e.ready = done;
    e.cyc   = in_c1;
    e.bsy   = 1'b1;
    e.to    = in_c1 && mem && !mr && (stalls == MAX_WAIT);
    simple = (ir[7:5] == 3'b000);
    isp    = (ir[7:5] == 3'b001);
    m      = ir[7] & ~ir[6] & c1;
    lj     = simple & ir[4] & ~ir[3];
    isalu  = (~ir[7] & ir[6]) | (c1 & ir[6] & ~ir[5]);
    issig  = simple & ir[4] & ir[3] & c0;
    e.strb = {m,
              ir[4],
              (ir[7:5] == 3'b111) & c1 & ~(ir[4] & cy),
              lj,
              lj & ir[1],
              lj & ir[2],
              m & ir[5] & done,
              ir[7] & c0,
              simple & ~ir[4] & ir[2],
              simple & ~ir[4] & ir[3],
              ir[5],
              ((m & ~ir[5]) | (isalu & ~(ir[4] & ~ir[3]))) & done,
              isp,
              ir[4] & (isalu | isp) & done};
    e.rs  = ir[1:0];
    e.alu = {ir[6] ? ir[3] : ~ir[7], ir[6] ? ir[2:0] : 3'b000};
    e.sig = issig ? (8'd1 << ir[2:0]) : 8'd0;
    return e;
  endfunction

  exp_t w_exp;
  logic w_acc;
  logic w_done;
  assign w_exp  = model_out(m_busy, m_in_c1, m_ir, m_stalls, carry, mem_ready);
  assign w_acc  = inst_valid & w_exp.ready;
  assign w_done = w_exp.ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_in_c1  <= 1'b0;
      m_ir     <= '0;
      m_stalls <= 0;
    end else if (!m_busy || w_done) begin
      m_in_c1  <= 1'b0;
      m_stalls <= 0;
      m_busy   <= w_acc;
      if (w_acc) m_ir <= inst;
    end else if (w_exp.to) begin
      m_busy   <= 1'b0;
      m_in_c1  <= 1'b0;
      m_stalls <= 0;
    end else if (!m_in_c1) begin
      m_in_c1 <= 1'b1;
    end else begin
      m_stalls <= m_stalls + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ctrl", 32'({inst_ready, cycle, busy, timeout}),
          32'({w_exp.ready, w_exp.cyc, w_exp.bsy, w_exp.to}));
      chk("model_strobes",
          32'({M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, WA, ISP, WC, RS, ALU, SIG}),
          32'({w_exp.strb, w_exp.rs, w_exp.alu, w_exp.sig}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int unsigned p_ready;

  initial begin
    rst_n = 1'b1; inst = '0; inst_valid = 1'b0; carry = 1'b0; mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(inst_ready), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_alu",   32'(ALU), 32'd0);
    step();
    rst_n = 1'b1;

    // Back-to-back single-cycle ALU stream
    inst = 8'h40; inst_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      inst = 8'(8'h41 + i);
      @(negedge clk);
      chk("b2b_wa",    32'(WA), 32'd1);
      chk("b2b_ready", 32'(inst_ready), 32'd1);
      chk("b2b_cycle", 32'(cycle), 32'd0);
      chk("b2b_alu",   32'(ALU), 32'(i));
      chk("b2b_rs",    32'(RS), 32'(i % 4));
    end
    step(); inst_valid = 1'b0;
    step();
    @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);

    // Store with three stalled cycles
    inst = 8'hA0; inst_valid = 1'b1; mem_ready = 1'b0;
    step(); inst_valid = 1'b0;
    @(negedge clk);
    chk("st_c0_mc",    32'(MC), 32'd1);
    chk("st_c0_ready", 32'(inst_ready), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 4) mem_ready = 1'b1;
      @(negedge clk);
      chk("st_c1_cycle", 32'(cycle), 32'd1);
      chk("st_c1_m",     32'(M), 32'd1);
      chk("st_c1_mw",    32'(MW), 32'(k == 4));
      chk("st_c1_ready", 32'(inst_ready), 32'(k == 4));
    end
    step(); mem_ready = 1'b0;
    @(negedge clk);
    chk("st_idle", 32'(busy), 32'd0);

    // Conditional jump, carry set then clear
    for (int c = 1; c >= 0; c--) begin
      carry = 1'(c); inst = 8'hF0; inst_valid = 1'b1;
      step(); inst_valid = 1'b0;
      @(negedge clk);
      chk("jmp_c0_j", 32'(J), 32'd0);
      step();
      @(negedge clk);
      chk("jmp_c1_cycle", 32'(cycle), 32'd1);
      chk("jmp_c1_j",     32'(J), 32'(c == 0));
      step();
      @(negedge clk);
      chk("jmp_idle", 32'(busy), 32'd0);
    end

    // Load that never completes: timeout on the 16th C1 cycle
    inst = 8'h80; inst_valid = 1'b1; mem_ready = 1'b0;
    step(); inst_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      @(negedge clk);
      chk("ld_timeout", 32'(timeout), 32'(k == 16));
      chk("ld_wa",      32'(WA), 32'd0);
      chk("ld_busy",    32'(busy), 32'd1);
    end
    step();
    @(negedge clk);
    chk("ld_idle",    32'(busy), 32'd0);
    chk("ld_to_gone", 32'(timeout), 32'd0);

    // Signal pulse
    inst = 8'h1D; inst_valid = 1'b1;
    step(); inst_valid = 1'b0;
    @(negedge clk);
    chk("sig_onehot", 32'(SIG), 32'h20);
    chk("sig_wa",     32'(WA), 32'd0);
    step();
    @(negedge clk);
    chk("sig_gone", 32'(SIG), 32'd0);

    // Reset while stalled in C1
    inst = 8'h80; inst_valid = 1'b1; mem_ready = 1'b0;
    step(); inst_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_c1_m",     32'(M), 32'd0);
    chk("rst_c1_busy",  32'(busy), 32'd0);
    chk("rst_c1_ready", 32'(inst_ready), 32'd1);
    step(); rst_n = 1'b1;

    // Randomized traffic
    p_ready = 80;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (n % 250 == 0) p_ready = (n % 750 == 0) ? 0 : ((n % 500 == 0) ? 25 : 80);
      rst_n      = ($urandom_range(0, 399) != 0);
      inst       = 8'($urandom);
      inst_valid = ($urandom_range(0, 3) != 0);
      carry      = 1'($urandom);
      mem_ready  = ($urandom_range(0, 99) < p_ready);
    end
    step();
    rst_n = 1'b1; inst_valid = 1'b0; mem_ready = 1'b1;
    repeat (4) step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
